// File: rtl/tnoc_flit_sender.sv
// Packet-to-flit transmitter: one request (VC, header, length) becomes a head flit followed by
// the payload words, tail-marked, on a registered per-VC valid/ready port. Optional parity: TNOC_FLIT_SENDER_PARITY_EN.
module tnoc_flit_sender #(
  parameter int CHANNELS    = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int MAX_PAYLOAD = 8,
  localparam int VC_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LEN_W = (MAX_PAYLOAD > 0) ? $clog2(MAX_PAYLOAD + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [VC_W-1:0]       i_req_vc,
  input  logic [DATA_WIDTH-1:0] i_req_header,
  input  logic [LEN_W-1:0]      i_req_length,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [CHANNELS-1:0]   o_flit_valid,
  input  logic [CHANNELS-1:0]   i_flit_ready,
  output logic                  o_flit_head,
  output logic                  o_flit_tail,
  output logic [DATA_WIDTH-1:0] o_flit_data,
  output logic                  o_flit_parity,
  output logic                  o_busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, PAYLOAD = 1'b1} state_t;

  state_t                state_r;
  state_t                next_state;
  logic [VC_W-1:0]       vc_r;
  logic [LEN_W-1:0]      remaining_r;
  logic [CHANNELS-1:0]   flit_valid_r;
  logic                  flit_head_r;
  logic                  flit_tail_r;
  logic [DATA_WIDTH-1:0] flit_data_r;

  logic                  flit_accept;
  logic                  slot_free;
  logic [LEN_W-1:0]      req_len_clamped;
  logic                  load;
  logic                  load_head;
  logic                  load_tail;
  logic [DATA_WIDTH-1:0] load_data;
  logic [CHANNELS-1:0]   load_valid;

  function automatic logic [CHANNELS-1:0] vc_onehot(input logic [VC_W-1:0] vc);
    logic [CHANNELS-1:0] oh;
    for (int i = 0; i < CHANNELS; i++) begin
      oh[i] = (vc == VC_W'(i));
    end
    return oh;
  endfunction

  // Valid is held only on the latched VC, so masking ready by it ignores the other VCs.
  assign flit_accept     = |(flit_valid_r & i_flit_ready);
  assign slot_free       = ~|flit_valid_r | flit_accept;
  assign req_len_clamped = (i_req_length > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : i_req_length;

  // Next state, handshake readies and the flit to load into the output register
  always_comb begin
    next_state   = state_r;
    o_req_ready  = 1'b0;
    o_data_ready = 1'b0;
    load         = 1'b0;
    load_head    = 1'b0;
    load_tail    = 1'b0;
    load_data    = i_data;
    load_valid   = vc_onehot(vc_r);
    case (state_r)
      IDLE: begin
        o_req_ready = slot_free;
        load_valid  = vc_onehot(i_req_vc);
        if (i_req_valid && slot_free) begin
          load       = 1'b1;
          load_head  = 1'b1;
          load_tail  = (req_len_clamped == LEN_W'(0));
          load_data  = i_req_header;
          next_state = (req_len_clamped == LEN_W'(0)) ? IDLE : PAYLOAD;
        end else begin
          next_state = IDLE;
        end
      end
      PAYLOAD: begin
        o_data_ready = slot_free;
        if (i_data_valid && slot_free) begin
          load       = 1'b1;
          load_tail  = (remaining_r == LEN_W'(1));
          next_state = (remaining_r == LEN_W'(1)) ? IDLE : PAYLOAD;
        end else begin
          next_state = PAYLOAD;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Packet control state: FSM, latched VC and payload words still to request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      vc_r        <= {VC_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
    end else begin
      state_r <= next_state;
      if (load && state_r == IDLE) begin
        vc_r        <= i_req_vc;
        remaining_r <= req_len_clamped;
      end else if (load) begin
        remaining_r <= remaining_r - LEN_W'(1);
      end
    end
  end

  // Output flit register: loads when the slot frees, otherwise holds until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_valid_r <= {CHANNELS{1'b0}};
      flit_head_r  <= 1'b0;
      flit_tail_r  <= 1'b0;
      flit_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (load) begin
      flit_valid_r <= load_valid;
      flit_head_r  <= load_head;
      flit_tail_r  <= load_tail;
      flit_data_r  <= load_data;
    end else if (flit_accept) begin
      flit_valid_r <= {CHANNELS{1'b0}};
    end
  end

`ifdef TNOC_FLIT_SENDER_PARITY_EN
  logic flit_parity_r;

  function automatic logic even_parity(input logic head, input logic tail,
                                       input logic [DATA_WIDTH-1:0] data);
    return ^{head, tail, data};
  endfunction

  // Parity travels with the flit it covers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_parity_r <= 1'b0;
    end else if (load) begin
      flit_parity_r <= even_parity(load_head, load_tail, load_data);
    end
  end

  assign o_flit_parity = flit_parity_r;
`else
  assign o_flit_parity = 1'b0;
`endif

  assign o_flit_valid = flit_valid_r;
  assign o_flit_head  = flit_head_r;
  assign o_flit_tail  = flit_tail_r;
  assign o_flit_data  = flit_data_r;
  assign o_busy       = (state_r != IDLE) | (|flit_valid_r);

endmodule

// File: tb/tb_tnoc_flit_sender.sv
// Scoreboard bench for tnoc_flit_sender: packets are expanded into expected flit sequences when
// issued; a negedge monitor pops and compares every accepted flit and checks hold-while-stalled.
module tb_tnoc_flit_sender;
  localparam int CH = 2, DW = 64, MAXP = 8, LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid, o_req_ready;
  logic [0:0]    i_req_vc;
  logic [DW-1:0] i_req_header;
  logic [LW-1:0] i_req_length;
  logic          i_data_valid, o_data_ready;
  logic [DW-1:0] i_data;
  logic [CH-1:0] o_flit_valid, i_flit_ready;
  logic          o_flit_head, o_flit_tail, o_flit_parity, o_busy;
  logic [DW-1:0] o_flit_data;

  always #5 clk = ~clk;

  tnoc_flit_sender #(.CHANNELS(CH), .DATA_WIDTH(DW), .MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_vc(i_req_vc),
    .i_req_header(i_req_header), .i_req_length(i_req_length),
    .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data(i_data),
    .o_flit_valid(o_flit_valid), .i_flit_ready(i_flit_ready),
    .o_flit_head(o_flit_head), .o_flit_tail(o_flit_tail), .o_flit_data(o_flit_data),
    .o_flit_parity(o_flit_parity), .o_busy(o_busy)
  );

  typedef struct packed {
    logic          vc;
    logic          head;
    logic          tail;
    logic [DW-1:0] data;
  } flit_t;

  typedef struct packed {
    logic                vc;
    logic [DW-1:0]       hdr;
    logic [LW-1:0]       len;
    logic [15:0][DW-1:0] words;
  } pkt_t;

  flit_t         exp_q[$];
  pkt_t          gen_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [CH-1:0] fixed_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_parity(input flit_t f);
`ifdef TNOC_FLIT_SENDER_PARITY_EN
    return ^{f.head, f.tail, f.data};
`else
    return 1'b0;
`endif
  endfunction

  // Reference: header flit, then min(len, MAXP) payload words, tail on the last flit.
  task automatic add_pkt(input logic vc, input logic [DW-1:0] hdr, input int len, input bit rnd);
    pkt_t  p;
    flit_t f;
    int    lc;
    lc = (len > MAXP) ? MAXP : len;
    p.vc  = vc;
    p.hdr = hdr;
    p.len = LW'(len);
    for (int i = 0; i < 16; i++) p.words[i] = rnd ? {$urandom, $urandom} : DW'(i + 1);
    gen_q.push_back(p);
    f.vc = vc; f.head = 1'b1; f.tail = (lc == 0); f.data = hdr;
    exp_q.push_back(f);
    for (int i = 0; i < lc; i++) begin
      f.head = 1'b0; f.tail = (i == lc - 1); f.data = p.words[i];
      exp_q.push_back(f);
    end
  endtask

  // Monitor: compare each accepted flit with the scoreboard; stalled flits must not change
  initial begin
    flit_t         e;
    logic          pend;
    logic [CH-1:0] pv;
    logic          ph, pt, pp;
    logic [DW-1:0] pd;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("hold_valid", 64'(o_flit_valid), 64'(pv));
          check("hold_fields", 64'({o_flit_head, o_flit_tail, o_flit_parity}), 64'({ph, pt, pp}));
          check("hold_data", o_flit_data, pd);
        end
        check("valid_onehot", 64'($countones(o_flit_valid) <= 1), 64'(1));
        if (|(o_flit_valid & i_flit_ready)) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_flit: got data 0x%0h expected no flit", o_flit_data);
          end else begin
            e = exp_q.pop_front();
            check("flit_valid", 64'(o_flit_valid), 64'(e.vc ? 2'b10 : 2'b01));
            check("flit_head", 64'(o_flit_head), 64'(e.head));
            check("flit_tail", 64'(o_flit_tail), 64'(e.tail));
            check("flit_data", o_flit_data, e.data);
            check("flit_parity", 64'(o_flit_parity), 64'(exp_parity(e)));
          end
          pend = 1'b0;
        end else begin
          pend = |o_flit_valid;
          pv = o_flit_valid; ph = o_flit_head; pt = o_flit_tail; pp = o_flit_parity; pd = o_flit_data;
        end
      end
    end
  end

  // Driver. mode 0: ready=fixed_rdy; 1: random valids/ready; 2: fixed_rdy but stalled in cycles 2..6.
  task automatic run(input int mode, input int stop_after, input int budget,
                     output int first, output int last, output int nacc, output int req_cyc);
    pkt_t cur;
    bit   have_cur, rf, df, stall;
    int   cyc, words_left, widx;
    cyc = 0; have_cur = 0; words_left = 0; widx = 0; cur = '0;
    first = -1; last = -1; nacc = 0; req_cyc = -1;
    while ((gen_q.size() > 0 || have_cur || exp_q.size() > 0) && nacc != stop_after && cyc < budget) begin
      stall = (mode == 2) && (cyc >= 2) && (cyc <= 6);
      i_req_valid = !have_cur && gen_q.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0);
      if (gen_q.size() > 0) begin
        i_req_vc = gen_q[0].vc; i_req_header = gen_q[0].hdr; i_req_length = gen_q[0].len;
      end
      i_data_valid = have_cur && (mode != 1 || $urandom_range(0, 3) != 0);
      i_data       = cur.words[widx];
      i_flit_ready = (mode == 1) ? CH'($urandom) : (stall ? '0 : fixed_rdy);
      @(negedge clk);
      rf = i_req_valid && o_req_ready;
      df = i_data_valid && o_data_ready;
      if (stall && o_flit_valid != '0)
        check("stall_readies", 64'({o_req_ready, o_data_ready}), 64'(0));
      if (|(o_flit_valid & i_flit_ready)) begin
        if (first < 0) first = cyc;
        last = cyc;
        nacc++;
      end
      if (rf) begin
        cur = gen_q.pop_front();
        words_left = (int'(cur.len) > MAXP) ? MAXP : int'(cur.len);
        widx = 0;
        have_cur = (words_left > 0);
        if (req_cyc < 0) req_cyc = cyc;
      end
      if (df) begin
        widx++; words_left--;
        if (words_left == 0) have_cur = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_req_valid = 1'b0; i_data_valid = 1'b0;
    if (cyc >= budget) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d flits pending after %0d cycles expected 0", exp_q.size(), cyc);
    end
  endtask

  initial begin
    int first, last, nacc, req_cyc;
    rst = 1'b1; i_req_valid = 1'b0; i_req_vc = '0; i_req_header = '0; i_req_length = '0;
    i_data_valid = 1'b0; i_data = '0; i_flit_ready = '0; fixed_rdy = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(o_flit_valid), 64'(0));
    check("rst_fields", 64'({o_flit_head, o_flit_tail, o_flit_parity}), 64'(0));
    check("rst_data", o_flit_data, 64'(0));
    check("rst_readies", 64'({o_req_ready, o_data_ready, o_busy}), 64'(3'b100));
    @(posedge clk); #1;

    // Header-only packet on VC1, only VC1 ready
    fixed_rdy = 2'b10;
    add_pkt(1'b1, 64'hA5, 0, 1'b0);
    run(0, -1, 50, first, last, nacc, req_cyc);
    check("len0_count", 64'(nacc), 64'(1));
    check("len0_latency", 64'(first - req_cyc), 64'(1));
    check("len0_busy", 64'(o_busy), 64'(0));

    // len 3, data 1,2,3, full throughput
    fixed_rdy = 2'b01;
    add_pkt(1'b0, 64'h1234_5678_9ABC_DEF0, 3, 1'b0);
    run(0, -1, 50, first, last, nacc, req_cyc);
    check("len3_count", 64'(nacc), 64'(4));
    check("len3_span", 64'(last - first), 64'(3));
    check("len3_latency", 64'(first - req_cyc), 64'(1));
    check("len3_after", 64'({o_data_ready, o_req_ready, o_busy}), 64'(3'b010));

    // Same packet with a 5-cycle stall on the second flit
    add_pkt(1'b0, 64'h1234_5678_9ABC_DEF0, 3, 1'b0);
    run(2, -1, 50, first, last, nacc, req_cyc);
    check("stall_count", 64'(nacc), 64'(4));
    check("stall_span", 64'(last - first), 64'(8));

    // Back-to-back len 2 then len 1: five flits on five consecutive cycles
    fixed_rdy = 2'b11;
    add_pkt(1'b0, 64'hB0, 2, 1'b1);
    add_pkt(1'b1, 64'hB1, 1, 1'b1);
    run(0, -1, 50, first, last, nacc, req_cyc);
    check("b2b_count", 64'(nacc), 64'(5));
    check("b2b_span", 64'(last - first), 64'(4));

    // Lengths above MAX_PAYLOAD are clamped; clamped packets still stream back-to-back
    add_pkt(1'b1, 64'hC0, 12, 1'b1);
    add_pkt(1'b0, 64'hC1, 15, 1'b1);
    run(0, -1, 100, first, last, nacc, req_cyc);
    check("clamp_count", 64'(nacc), 64'(18));
    check("clamp_span", 64'(last - first), 64'(17));

    // Reset after the second payload flit of a len 4 packet
    add_pkt(1'b1, 64'hD0, 4, 1'b1);
    run(0, 3, 50, first, last, nacc, req_cyc);
    check("pre_rst_count", 64'(nacc), 64'(3));
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(o_flit_valid), 64'(0));
    check("rst_mid_state", 64'({o_req_ready, o_data_ready, o_busy}), 64'(3'b100));
    exp_q.delete();
    gen_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    add_pkt(1'b0, 64'hE0, 1, 1'b1);
    run(0, -1, 50, first, last, nacc, req_cyc);
    check("post_rst_count", 64'(nacc), 64'(2));
    check("post_rst_span", 64'(last - first), 64'(1));

    // Randomised traffic with random per-VC backpressure
    for (int i = 0; i < 40; i++)
      add_pkt(1'($urandom), {$urandom, $urandom}, $urandom_range(0, 15), 1'b1);
    run(1, -1, 5000, first, last, nacc, req_cyc);
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_busy", 64'(o_busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
